// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the packet-aware FIFO push arbiter.
// Holds the arbiter state encoding and a small index-wrap helper.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Successor of idx in a ring of n entries.
    function automatic int wrap_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotating first-one search: returns the first asserted request found
// scanning from ptr upward, wrapping modulo n_req.
module rr_priority_select #(
    parameter int n_req = 4,
    localparam int iw = $clog2(n_req)
) (
    input  logic [n_req-1:0] req,
    input  logic [iw-1:0]    ptr,
    output logic             found,
    output logic [iw-1:0]    index
);

    logic [iw:0]      cand_wide [n_req];
    logic [iw-1:0]    cand      [n_req];
    logic [n_req-1:0] rot;

    // rot[k] is the request sitting k positions after ptr in the ring.
    for (genvar gi = 0; gi < n_req; gi++) begin : g_rot
        assign cand_wide[gi] = {1'b0, ptr} + (iw + 1)'(gi);
        assign cand[gi]      = (cand_wide[gi] >= (iw + 1)'(n_req))
                             ? iw'(cand_wide[gi] - (iw + 1)'(n_req))
                             : cand_wide[gi][iw-1:0];
        assign rot[gi]       = req[cand[gi]];
    end

    // Scan from the far end so the closest-to-ptr hit is written last.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = n_req - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                index = cand[k];
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter feeding one FIFO push port; a multi-beat packet
// keeps ownership of the FIFO until its last beat has been accepted.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int n_req = 4,
    parameter int width = 8,
    localparam int iw = $clog2(n_req)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [n_req-1:0]       req_valid,
    input  logic [n_req-1:0]       req_last,
    input  logic [n_req*width-1:0] req_data,
    output logic [n_req-1:0]       req_ready,
    input  logic                   fifo_full,
    output logic                   fifo_push,
    output logic [width-1:0]       fifo_write_data,
    output logic [iw-1:0]          grant_id,
    output logic                   locked
);

    arb_state_t     state_reg;
    logic [iw-1:0]  rr_ptr_reg;
    logic [iw-1:0]  owner_reg;

    logic           rr_found;
    logic [iw-1:0]  rr_index;
    logic [iw-1:0]  winner;
    logic           winner_valid;
    logic           winner_last;
    logic           accept;
    logic [width-1:0] data_arr [n_req];

    rr_priority_select #(
        .n_req (n_req)
    ) u_rr_select (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .found (rr_found),
        .index (rr_index)
    );

    for (genvar gi = 0; gi < n_req; gi++) begin : g_data
        assign data_arr[gi] = req_data[gi*width +: width];
    end

    // While locked only the owner is considered; everyone else is ignored.
    always_comb begin
        if (state_reg == LOCKED) begin
            winner       = owner_reg;
            winner_valid = req_valid[owner_reg];
        end else begin
            winner       = rr_index;
            winner_valid = rr_found;
        end
    end

    assign accept          = winner_valid && !fifo_full;
    assign winner_last     = req_last[winner];
    assign fifo_push       = accept;
    assign fifo_write_data = data_arr[winner];
    assign grant_id        = winner;
    assign locked          = (state_reg == LOCKED);

    for (genvar gi = 0; gi < n_req; gi++) begin : g_ready
        assign req_ready[gi] = accept && (winner == iw'(gi));
    end

    // Reset drops any packet in flight; it is not resumed afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
        end else if (accept) begin
            if (winner_last) begin
                state_reg  <= IDLE;
                rr_ptr_reg <= iw'(wrap_next(int'(winner), n_req));
            end else if (state_reg == IDLE) begin
                state_reg <= LOCKED;
                owner_reg <= winner;
            end
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: per-scenario tasks with
// hand-computed expectations and a model FIFO for the wrap scenario.
module tb_fifo_push_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct packed {
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic         f;
        logic         p;
        logic         lk;
        logic [1:0]   g;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_push;
    logic [W-1:0]   fifo_write_data;
    logic [1:0]     grant_id;
    logic           locked;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_push_arbiter #(
        .n_req (N),
        .width (W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_last        (req_last),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .fifo_full       (fifo_full),
        .fifo_push       (fifo_push),
        .fifo_write_data (fifo_write_data),
        .grant_id        (grant_id),
        .locked          (locked)
    );

    // Apply inputs just after a rising edge, return at the falling edge.
    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
        @(posedge clk);
        #1;
        req_valid = v;
        req_last  = l;
        fifo_full = f;
        @(negedge clk);
    endtask

    task automatic show(input string name);
        $display("[%0t] %s valid=%b last=%b full=%b push=%b ready=%b grant=%0d locked=%b data=%h",
                 $time, name, req_valid, req_last, fifo_full, fifo_push, req_ready,
                 grant_id, locked, fifo_write_data);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0);
        show("reset_idle");
        checks++;
        if (locked !== 1'b0 || fifo_push !== 1'b0 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle: locked=%b push=%b ready=%b, required 0 0 0000", locked, fifo_push, req_ready);
        end
        drive(4'b0100, 4'b0000, 1'b0);
        show("reset_comb");
        checks++;
        if (fifo_push !== 1'b1 || req_ready !== 4'b0100 || grant_id !== 2'd2 || locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_comb: push=%b ready=%b grant=%0d locked=%b, required 1 0100 2 0",
                     fifo_push, req_ready, grant_id, locked);
        end
        drive(4'b0000, 4'b0000, 1'b0);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold_lock: locked=%b required 0", locked);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_ready;
        logic [W-1:0] exp_data;
        for (int i = 0; i < 4; i++) begin
            drive(4'b1111, 4'b1111, 1'b0);
            show("round_robin");
            exp_ready = 4'b0001 << i;
            exp_data  = 8'hA0 + 8'(i);
            checks++;
            if (grant_id !== 2'(i) || fifo_push !== 1'b1 || req_ready !== exp_ready ||
                fifo_write_data !== exp_data || locked !== 1'b0) begin
                failures++;
                $display("FAIL round_robin[%0d]: grant=%0d push=%b ready=%b data=%h locked=%b, required %0d 1 %b %h 0",
                         i, grant_id, fifo_push, req_ready, fifo_write_data, locked, i, exp_ready, exp_data);
            end
        end
    endtask

    task automatic test_locked_packet();
        vec_t tbl [6] = '{
            '{v: 4'b0010, l: 4'b1111, f: 1'b0, p: 1'b1, lk: 1'b0, g: 2'd1},
            '{v: 4'b0111, l: 4'b0000, f: 1'b0, p: 1'b1, lk: 1'b0, g: 2'd2},
            '{v: 4'b0111, l: 4'b0000, f: 1'b0, p: 1'b1, lk: 1'b1, g: 2'd2},
            '{v: 4'b0111, l: 4'b0100, f: 1'b0, p: 1'b1, lk: 1'b1, g: 2'd2},
            '{v: 4'b1011, l: 4'b1111, f: 1'b0, p: 1'b1, lk: 1'b0, g: 2'd3},
            '{v: 4'b0011, l: 4'b1111, f: 1'b0, p: 1'b1, lk: 1'b0, g: 2'd0}
        };
        logic [N-1:0] exp_ready;
        for (int s = 0; s < 6; s++) begin
            drive(tbl[s].v, tbl[s].l, tbl[s].f);
            show("locked_packet");
            exp_ready = tbl[s].p ? (4'b0001 << tbl[s].g) : 4'b0000;
            checks++;
            if (fifo_push !== tbl[s].p || req_ready !== exp_ready || locked !== tbl[s].lk ||
                grant_id !== tbl[s].g || fifo_write_data !== 8'hA0 + 8'(tbl[s].g)) begin
                failures++;
                $display("FAIL locked_packet[%0d]: push=%b ready=%b locked=%b grant=%0d data=%h, required %b %b %b %0d",
                         s, fifo_push, req_ready, locked, grant_id, fifo_write_data,
                         tbl[s].p, exp_ready, tbl[s].lk, tbl[s].g);
            end
        end
    endtask

    task automatic test_full_stall();
        vec_t tbl [9] = '{
            '{v: 4'b1111, l: 4'b1111, f: 1'b1, p: 1'b0, lk: 1'b0, g: 2'd0},
            '{v: 4'b1111, l: 4'b1111, f: 1'b1, p: 1'b0, lk: 1'b0, g: 2'd0},
            '{v: 4'b1111, l: 4'b1111, f: 1'b1, p: 1'b0, lk: 1'b0, g: 2'd0},
            '{v: 4'b1111, l: 4'b1111, f: 1'b0, p: 1'b1, lk: 1'b0, g: 2'd1},
            '{v: 4'b1000, l: 4'b1111, f: 1'b1, p: 1'b0, lk: 1'b0, g: 2'd0},
            '{v: 4'b1100, l: 4'b1111, f: 1'b0, p: 1'b1, lk: 1'b0, g: 2'd2},
            '{v: 4'b0001, l: 4'b0000, f: 1'b0, p: 1'b1, lk: 1'b0, g: 2'd0},
            '{v: 4'b0001, l: 4'b0000, f: 1'b1, p: 1'b0, lk: 1'b1, g: 2'd0},
            '{v: 4'b0001, l: 4'b0001, f: 1'b0, p: 1'b1, lk: 1'b1, g: 2'd0}
        };
        logic [N-1:0] exp_ready;
        for (int s = 0; s < 9; s++) begin
            drive(tbl[s].v, tbl[s].l, tbl[s].f);
            show("full_stall");
            exp_ready = tbl[s].p ? (4'b0001 << tbl[s].g) : 4'b0000;
            checks++;
            if (fifo_push !== tbl[s].p || req_ready !== exp_ready || locked !== tbl[s].lk ||
                ((tbl[s].p || tbl[s].lk) && grant_id !== tbl[s].g)) begin
                failures++;
                $display("FAIL full_stall[%0d]: push=%b ready=%b locked=%b grant=%0d, required %b %b %b %0d",
                         s, fifo_push, req_ready, locked, grant_id,
                         tbl[s].p, exp_ready, tbl[s].lk, tbl[s].g);
            end
        end
    endtask

    task automatic test_owner_gap();
        vec_t tbl [5] = '{
            '{v: 4'b0010, l: 4'b0000, f: 1'b0, p: 1'b1, lk: 1'b0, g: 2'd1},
            '{v: 4'b0001, l: 4'b0001, f: 1'b0, p: 1'b0, lk: 1'b1, g: 2'd1},
            '{v: 4'b0001, l: 4'b0001, f: 1'b0, p: 1'b0, lk: 1'b1, g: 2'd1},
            '{v: 4'b0011, l: 4'b0010, f: 1'b0, p: 1'b1, lk: 1'b1, g: 2'd1},
            '{v: 4'b1111, l: 4'b1111, f: 1'b0, p: 1'b1, lk: 1'b0, g: 2'd2}
        };
        logic [N-1:0] exp_ready;
        for (int s = 0; s < 5; s++) begin
            drive(tbl[s].v, tbl[s].l, tbl[s].f);
            show("owner_gap");
            exp_ready = tbl[s].p ? (4'b0001 << tbl[s].g) : 4'b0000;
            checks++;
            if (fifo_push !== tbl[s].p || req_ready !== exp_ready || locked !== tbl[s].lk ||
                grant_id !== tbl[s].g) begin
                failures++;
                $display("FAIL owner_gap[%0d]: push=%b ready=%b locked=%b grant=%0d, required %b %b %b %0d",
                         s, fifo_push, req_ready, locked, grant_id,
                         tbl[s].p, exp_ready, tbl[s].lk, tbl[s].g);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        drive(4'b1000, 4'b0000, 1'b0);
        show("reset_mid_start");
        checks++;
        if (grant_id !== 2'd3 || fifo_push !== 1'b1 || locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_start: grant=%0d push=%b locked=%b, required 3 1 0", grant_id, fifo_push, locked);
        end
        drive(4'b1001, 4'b0000, 1'b0);
        show("reset_mid_locked");
        checks++;
        if (grant_id !== 2'd3 || req_ready !== 4'b1000 || locked !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_locked: grant=%0d ready=%b locked=%b, required 3 1000 1", grant_id, req_ready, locked);
        end
        rst = 1'b1;
        drive(4'b1001, 4'b1111, 1'b0);
        rst = 1'b0;
        show("reset_mid_after");
        checks++;
        if (locked !== 1'b0 || grant_id !== 2'd0 || req_ready !== 4'b0001 || fifo_write_data !== 8'hA0) begin
            failures++;
            $display("FAIL reset_mid_after: locked=%b grant=%0d ready=%b data=%h, required 0 0 0001 a0",
                     locked, grant_id, req_ready, fifo_write_data);
        end
        drive(4'b1111, 4'b1111, 1'b0);
        show("reset_mid_next");
        checks++;
        if (grant_id !== 2'd1 || req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL reset_mid_next: grant=%0d ready=%b, required 1 0010", grant_id, req_ready);
        end
    endtask

    task automatic test_wrap_scoreboard();
        logic [W-1:0] exp_q[$];
        logic [W-1:0] exp_data;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            req_data[3*W +: W] = 8'h30 + 8'(k * 7);
            exp_q.push_back(8'h30 + 8'(k * 7));
            req_valid = 4'b1000;
            req_last  = 4'b1000;
            fifo_full = 1'b0;
            @(negedge clk);
            show("wrap_beat");
            checks++;
            if (fifo_push !== 1'b1 || grant_id !== 2'd3 || req_ready !== 4'b1000 || locked !== 1'b0) begin
                failures++;
                $display("FAIL wrap_beat[%0d]: push=%b grant=%0d ready=%b locked=%b, required 1 3 1000 0",
                         k, fifo_push, grant_id, req_ready, locked);
            end
            if (fifo_push === 1'b1 && exp_q.size() > 0) begin
                exp_data = exp_q.pop_front();
                checks++;
                if (fifo_write_data !== exp_data) begin
                    failures++;
                    $display("FAIL wrap_data[%0d]: data=%h required %h", k, fifo_write_data, exp_data);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_pending: %0d beats never pushed, required 0", exp_q.size());
        end
        drive(4'b1001, 4'b1111, 1'b0);
        show("wrap_after");
        checks++;
        if (grant_id !== 2'd0 || req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_after: grant=%0d ready=%b, required 0 0001", grant_id, req_ready);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'hA0 + 8'(i);

        test_reset();
        test_round_robin();
        test_locked_packet();
        test_full_stall();
        test_owner_gap();
        test_reset_mid_packet();
        test_wrap_scoreboard();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
